// File: rtl/reg_status_file.sv
// Architectural register file with rename status (valid / producer tag) and a
// single-level speculative checkpoint. Serves RD_CH dispatch channels with two
// source ports each, absorbs CDB_CH result broadcasts, and restores or commits
// state clobbered by tagged (speculative) renames.
module reg_status_file #(
  parameter int XLEN   = 32,
  parameter int REGS   = 32,
  parameter int TAG_W  = 6,
  parameter int RD_CH  = 2,
  parameter int REN_CH = 2,
  parameter int CDB_CH = 2,
  localparam int RW    = $clog2(REGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      delete_tagged,
  input  logic                      clear_tags,
  input  logic [RD_CH*2*RW-1:0]     rd_reg,
  output logic [RD_CH*2*XLEN-1:0]   rd_data,
  output logic [RD_CH*2-1:0]        rd_valid,
  output logic [RD_CH*2*TAG_W-1:0]  rd_tag,
  input  logic [REN_CH-1:0]         ren_valid,
  input  logic [REN_CH*RW-1:0]      ren_reg,
  input  logic [REN_CH*TAG_W-1:0]   ren_tag,
  input  logic [REN_CH-1:0]         ren_spec,
  input  logic [CDB_CH-1:0]         cdb_valid,
  input  logic [CDB_CH*TAG_W-1:0]   cdb_tag,
  input  logic [CDB_CH*XLEN-1:0]    cdb_data,
  output logic [XLEN-1:0]           dbg_reg_11
);

  localparam int RP      = RD_CH * 2;
  localparam int DBG_REG = (REGS > 11) ? 11 : 0;

  // Live state
  logic [XLEN-1:0]  data_q  [REGS];
  logic [XLEN-1:0]  data_d  [REGS];
  logic [REGS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q   [REGS];
  logic [TAG_W-1:0] tag_d   [REGS];
  logic [REGS-1:0]  spec_q, spec_d;

  // Checkpoint copy, meaningful only while spec is set
  logic [XLEN-1:0]  sdata_q [REGS];
  logic [XLEN-1:0]  sdata_d [REGS];
  logic [REGS-1:0]  svalid_q, svalid_d;
  logic [TAG_W-1:0] stag_q  [REGS];
  logic [TAG_W-1:0] stag_d  [REGS];

  // Broadcast lookup; scanning from the top lets the lowest channel win.
  function automatic void cdb_lookup(input  logic [TAG_W-1:0] t,
                                     output logic             hit,
                                     output logic [XLEN-1:0]  val);
    hit = 1'b0;
    val = '0;
    for (int unsigned c = CDB_CH; c > 0; c--) begin
      if (cdb_valid[c-1] && (cdb_tag[(c-1)*TAG_W +: TAG_W] == t)) begin
        hit = 1'b1;
        val = cdb_data[(c-1)*XLEN +: XLEN];
      end
    end
  endfunction

  // Next-state: restore/commit, then CDB wakeup, then renames (with checkpoint capture)
  always_comb begin
    logic             hit;
    logic [XLEN-1:0]  hval;
    logic             any_ren;
    logic             any_spec;
    logic [TAG_W-1:0] new_tag;

    hit      = 1'b0;
    hval     = '0;
    any_ren  = 1'b0;
    any_spec = 1'b0;
    new_tag  = '0;
    valid_d  = valid_q;
    spec_d   = spec_q;
    svalid_d = svalid_q;
    for (int unsigned i = 0; i < REGS; i++) begin
      data_d[i]  = data_q[i];
      tag_d[i]   = tag_q[i];
      sdata_d[i] = sdata_q[i];
      stag_d[i]  = stag_q[i];
    end

    for (int unsigned i = 0; i < REGS; i++) begin
      // Squash: roll back tagged registers to their checkpoint
      if (delete_tagged && spec_q[i]) begin
        data_d[i]  = sdata_q[i];
        valid_d[i] = svalid_q[i];
        tag_d[i]   = stag_q[i];
      end
      if (delete_tagged || clear_tags) begin
        spec_d[i] = 1'b0;
      end

      // Wakeup acts on the possibly-restored live state
      if (!valid_d[i]) begin
        cdb_lookup(tag_d[i], hit, hval);
        if (hit) begin
          data_d[i]  = hval;
          valid_d[i] = 1'b1;
        end
      end

      // Checkpoint also listens so a later restore sees the produced value
      if (!svalid_q[i]) begin
        cdb_lookup(stag_q[i], hit, hval);
        if (hit) begin
          sdata_d[i]  = hval;
          svalid_d[i] = 1'b1;
        end
      end

      // Collapse all rename channels targeting this register; highest channel
      // supplies the tag, any tagged channel requests a checkpoint.
      any_ren  = 1'b0;
      any_spec = 1'b0;
      new_tag  = '0;
      for (int unsigned ch = 0; ch < REN_CH; ch++) begin
        if (ren_valid[ch] && (ren_reg[ch*RW +: RW] == RW'(i))) begin
          any_ren = 1'b1;
          new_tag = ren_tag[ch*TAG_W +: TAG_W];
          if (ren_spec[ch]) begin
            any_spec = 1'b1;
          end
        end
      end

      if (any_ren && !delete_tagged && (i != 0)) begin
        // Capture the post-wakeup, pre-rename value once per speculation window
        if (any_spec && !spec_d[i]) begin
          sdata_d[i]  = data_d[i];
          svalid_d[i] = valid_d[i];
          stag_d[i]   = tag_d[i];
          spec_d[i]   = 1'b1;
        end
        valid_d[i] = 1'b0;
        tag_d[i]   = new_tag;
      end
    end

    // Register 0 is hardwired to a ready zero
    data_d[0]   = '0;
    valid_d[0]  = 1'b1;
    tag_d[0]    = '0;
    spec_d[0]   = 1'b0;
    sdata_d[0]  = '0;
    svalid_d[0] = 1'b1;
    stag_d[0]   = '0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '1;
      spec_q   <= '0;
      svalid_q <= '1;
      for (int unsigned i = 0; i < REGS; i++) begin
        data_q[i]  <= '0;
        tag_q[i]   <= '0;
        sdata_q[i] <= '0;
        stag_q[i]  <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      spec_q   <= spec_d;
      svalid_q <= svalid_d;
      for (int unsigned i = 0; i < REGS; i++) begin
        data_q[i]  <= data_d[i];
        tag_q[i]   <= tag_d[i];
        sdata_q[i] <= sdata_d[i];
        stag_q[i]  <= stag_d[i];
      end
    end
  end

  // Zero-latency source reads with same-cycle CDB bypass
  always_comb begin
    logic [RW-1:0]   idx;
    logic            hit;
    logic [XLEN-1:0] hval;

    idx      = '0;
    hit      = 1'b0;
    hval     = '0;
    rd_data  = '0;
    rd_valid = '0;
    rd_tag   = '0;
    for (int unsigned p = 0; p < RP; p++) begin
      idx = rd_reg[p*RW +: RW];
      if (valid_q[idx]) begin
        rd_data[p*XLEN +: XLEN] = data_q[idx];
        rd_valid[p]             = 1'b1;
      end else begin
        cdb_lookup(tag_q[idx], hit, hval);
        if (hit) begin
          rd_data[p*XLEN +: XLEN] = hval;
          rd_valid[p]             = 1'b1;
        end else begin
          rd_tag[p*TAG_W +: TAG_W] = tag_q[idx];
        end
      end
    end
  end

  assign dbg_reg_11 = data_q[DBG_REG];

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Parametrised successor to the two-source register value path: architectural register file plus per-register rename status (valid, producer tag).
- Serves RD_CH dispatch channels, each with two source ports, and absorbs CDB_CH result broadcasts.
- Adds one level of speculative checkpoint: on delete_tagged, state clobbered by tagged renames is restored; on clear_tags, it is committed.
- Sits between rename/dispatch and the reservation stations, driven by ROB global signals.

Parameters:
- XLEN, 32, data width
- REGS, 32, architectural register count (index width RW = $clog2(REGS))
- TAG_W, 6, producer tag width (matches src width)
- RD_CH, 2, dispatch read channels (two sources each)
- REN_CH, 2, rename channels per cycle
- CDB_CH, 2, result broadcast channels

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- delete_tagged  in  1  squash speculative renames
- clear_tags  in  1  commit speculative renames
- rd_reg  in  RD_CH*2*RW  source register indices
- rd_data  out  RD_CH*2*XLEN  source data (combinational)
- rd_valid  out  RD_CH*2  source value ready
- rd_tag  out  RD_CH*2*TAG_W  producer tag when not ready, else 0
- ren_valid  in  REN_CH  rename request
- ren_reg  in  REN_CH*RW  destination register
- ren_tag  in  REN_CH*TAG_W  new producer tag
- ren_spec  in  REN_CH  rename is under an unresolved branch (tagged)
- cdb_valid  in  CDB_CH  broadcast valid
- cdb_tag  in  CDB_CH*TAG_W  broadcast tag
- cdb_data  in  CDB_CH*XLEN  broadcast result
- dbg_reg_11  out  XLEN  live data of register 11

Behaviour:
- Per register i: data, valid, tag, spec, plus saved_data, saved_valid, saved_tag.
- Reset (synchronous): all data 0, valid 1, tag 0, spec 0, saved copies 0/1/0. Outputs follow combinationally: rd_valid all 1, rd_data 0, rd_tag 0, dbg_reg_11 0.
- Register 0: always data 0, valid 1, tag 0; renames to it are ignored.
- Reads, 0 latency:
  - valid -> data, valid 1, tag 0.
  - Else, if any cdb_valid with cdb_tag == tag this cycle -> bypass: cdb_data, valid 1, tag 0.
  - Else -> data 0, valid 0, stored tag.
  - Reads see pre-rename state; intra-bundle dependencies are resolved by dispatch.
- Per clock edge, priority order:
  1. delete_tagged: every spec=1 register restores data/valid/tag from its saved copy; spec <= 0. Renames this cycle are dropped. CDB is then applied to the restored state.
  2. clear_tags (only if delete_tagged is low): spec <= 0 for all registers; saved copies become don't-care.
  3. CDB: any register with valid=0 and tag matching a valid broadcast gets data <= cdb_data, valid <= 1. Saved copies with saved_valid=0 and a matching saved_tag are updated the same way.
  4. Renames: valid <= 0, tag <= ren_tag.
     - Rename overrides a same-cycle CDB hit on the live state.
     - ren_spec=1 with spec=0 (after step 2) captures the post-CDB live state into the saved copy, then sets spec <= 1.
     - ren_spec=1 with spec=1 already set: saved copy untouched.
     - ren_spec=0: spec unchanged.
     - Several channels to the same register: highest channel index wins for tag. Capture uses pre-rename state and happens once.
- Tags are unique among in-flight producers (ROB guarantee). Duplicate CDB tags in one cycle are unsupported; the lowest channel wins.
- dbg_reg_11 = registered data of register 11 (no bypass).
- Reset asserted mid-speculation discards all spec and saved state.

Test Plan:
- Reset, read x5/x0 on all ports -> rd_valid=1, rd_data=0, rd_tag=0.
- Rename x3 tag 7 (non-spec); next cycle read x3 -> valid 0, tag 7. CDB tag 7 data 0xDEAD in the same cycle as the read -> bypass 0xDEAD valid 1. Following cycle -> stored 0xDEAD.
- x4=0x11 committed; spec rename x4 tag 9, CDB 9 data 0x22; delete_tagged -> x4 reads 0x11 valid 1. Repeat with clear_tags instead -> 0x22.
- Spec rename x6 tag 3 while x6 pending on tag 2; CDB tag 2 data 0x55; delete_tagged -> x6 valid 1, data 0x55.
- Channels 0 and 1 both rename x8 (tags 4, 5) with a CDB hit on x8's old tag in the same cycle -> x8 tag 5, valid 0.
- Rename x0 tag 1 -> x0 still valid 1, data 0. delete_tagged and clear_tags together -> restore occurs.
